// File: rtl/econet_tx_ctrl_if.sv
// Host buffer/command port and tx PHY handshake bundled for econet_tx_ctrl.
// The slave modport is the controller's view; master is the host/PHY side.
interface econet_tx_ctrl_if #(
  parameter int unsigned ADDR_W = 8
);
  logic              buf_we;
  logic [ADDR_W-1:0] buf_addr;
  logic [7:0]        buf_wdata;
  logic [ADDR_W:0]   tx_len;
  logic              tx_go;
  logic              tx_abort;
  logic              line_idle;
  logic              busy;
  logic              done;
  logic [1:0]        tx_status;
  logic [7:0]        tx_byte;
  logic              start_frame;
  logic              end_frame;
  logic              request_byte;
  logic              transmitting;

  modport slave (
    input  buf_we, buf_addr, buf_wdata, tx_len, tx_go, tx_abort, line_idle,
    input  request_byte, transmitting,
    output busy, done, tx_status, tx_byte, start_frame, end_frame
  );

  modport master (
    output buf_we, buf_addr, buf_wdata, tx_len, tx_go, tx_abort, line_idle,
    output request_byte, transmitting,
    input  busy, done, tx_status, tx_byte, start_frame, end_frame
  );
endinterface

// File: rtl/econet_tx_ctrl.sv
// Econet transmit frame sequencer: buffers one frame, defers for an idle line,
// then feeds the tx PHY one byte per request and reports completion status.
module econet_tx_ctrl #(
  parameter int unsigned ADDR_W   = 8,
  parameter int unsigned IDLE_GAP = 16,
  parameter int unsigned TIMEOUT  = 65535
) (
  input  logic              econet_clk,
  input  logic              reset,
  econet_tx_ctrl_if.slave   bus
);

  localparam int unsigned Depth  = 1 << ADDR_W;
  localparam logic [15:0] GapMax = 16'(IDLE_GAP);
  localparam logic [15:0] TmoMax = 16'(TIMEOUT);

  typedef enum logic [2:0] {StIdle, StDefer, StStart, StSend, StDrain} state_e;

  state_e          state_q, state_d;
  logic [ADDR_W:0] len_q, len_d;
  logic [ADDR_W:0] ptr_q, ptr_d;
  logic [15:0]     gap_q, gap_d;
  logic [15:0]     tmo_q, tmo_d;
  logic            req_q;
  logic            abort_q, abort_d;
  logic            done_q, done_d;
  logic [1:0]      status_q, status_d;
  logic [7:0]      tx_byte_q, tx_byte_d;
  logic            start_q, start_d;
  logic            end_q, end_d;
  logic            consumed;
  logic            len_bad;

  logic [7:0] mem_q [Depth];

  always_ff @(posedge econet_clk) begin
    if (bus.buf_we && (state_q == StIdle)) begin
      mem_q[bus.buf_addr] <= bus.buf_wdata;
    end
  end

  // The PHY may stretch a request over stuff cycles; act only once it drops.
  assign consumed = req_q & ~bus.request_byte;
  assign len_bad  = (bus.tx_len == '0) ||
                    (bus.tx_len[ADDR_W] && (bus.tx_len[ADDR_W-1:0] != '0));

  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    ptr_d     = ptr_q;
    gap_d     = gap_q;
    tmo_d     = tmo_q;
    abort_d   = abort_q;
    done_d    = 1'b0;
    status_d  = status_q;
    start_d   = 1'b0;
    end_d     = end_q;
    tx_byte_d = tx_byte_q;

    if (state_q != StIdle) begin
      tx_byte_d = mem_q[ptr_q[ADDR_W-1:0]];
    end

    unique case (state_q)
      StIdle: begin
        if (bus.tx_go) begin
          if (len_bad) begin
            done_d   = 1'b1;
            status_d = 2'b11;
          end else begin
            len_d   = bus.tx_len;
            ptr_d   = '0;
            gap_d   = '0;
            tmo_d   = '0;
            abort_d = 1'b0;
            end_d   = 1'b0;
            state_d = StDefer;
          end
        end
      end
      StDefer: begin
        gap_d = bus.line_idle ? (gap_q + 16'd1) : 16'd0;
        tmo_d = tmo_q + 16'd1;
        if (bus.tx_abort) begin
          done_d   = 1'b1;
          status_d = 2'b10;
          state_d  = StIdle;
        end else if (tmo_d == TmoMax) begin
          done_d   = 1'b1;
          status_d = 2'b01;
          state_d  = StIdle;
        end else if (gap_d == GapMax) begin
          start_d = 1'b1;
          state_d = StStart;
        end
      end
      StStart: begin
        if (bus.tx_abort) begin
          abort_d = 1'b1;
        end
        state_d = StSend;
      end
      StSend: begin
        if (bus.tx_abort) begin
          abort_d = 1'b1;
        end
        if (consumed) begin
          if (end_q) begin
            state_d = StDrain;
          end else if (ptr_q < len_q) begin
            ptr_d = ptr_q + 1'b1;
          end
        end
        // end_frame only moves while no request is outstanding.
        if (state_d == StDrain) begin
          end_d = 1'b0;
        end else if (!bus.request_byte) begin
          end_d = (ptr_d == len_q) || abort_d;
        end
      end
      StDrain: begin
        if (!bus.transmitting) begin
          done_d   = 1'b1;
          status_d = abort_q ? 2'b10 : 2'b00;
          state_d  = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge econet_clk or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      len_q     <= '0;
      ptr_q     <= '0;
      gap_q     <= '0;
      tmo_q     <= '0;
      req_q     <= 1'b0;
      abort_q   <= 1'b0;
      done_q    <= 1'b0;
      status_q  <= 2'b00;
      tx_byte_q <= 8'h00;
      start_q   <= 1'b0;
      end_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      ptr_q     <= ptr_d;
      gap_q     <= gap_d;
      tmo_q     <= tmo_d;
      req_q     <= bus.request_byte;
      abort_q   <= abort_d;
      done_q    <= done_d;
      status_q  <= status_d;
      tx_byte_q <= tx_byte_d;
      start_q   <= start_d;
      end_q     <= end_d;
    end
  end

  assign bus.busy        = (state_q != StIdle);
  assign bus.done        = done_q;
  assign bus.tx_status   = status_q;
  assign bus.tx_byte     = tx_byte_q;
  assign bus.start_frame = start_q;
  assign bus.end_frame   = end_q;

endmodule

// File: doc/econet_tx_ctrl.md
Name: econet_tx_ctrl

Overview:
- Frame sequencer for the Econet transmit PHY.
- Holds one outgoing frame in an internal byte buffer that the host loads.
- On a host "go", it waits for the line to be idle, starts the PHY and feeds one byte per PHY request.
- It flags the last byte via end_frame, waits for the PHY to drain and reports completion status.
- Sits between the host register interface and the tx PHY, in the econet_clk domain.

Parameters:
- ADDR_W, 8, buffer address width; DEPTH = 2**ADDR_W bytes.
- IDLE_GAP, 16, consecutive line_idle cycles required before start_frame.
- TIMEOUT, 65535, max cycles in DEFER before giving up (counter 16 bits).

Ports:
- econet_clk  in  1  bit clock, shared with the PHY
- reset  in  1  asynchronous, active-high reset
- buf_we  in  1  host buffer write strobe
- buf_addr  in  ADDR_W  host write address
- buf_wdata  in  8  host write data
- tx_len  in  ADDR_W+1  frame length in bytes, sampled on tx_go
- tx_go  in  1  start request (level/pulse; sampled in IDLE only)
- tx_abort  in  1  abort request
- line_idle  in  1  receiver reports no carrier/flags on the line
- busy  out  1  controller not in IDLE
- done  out  1  one-cycle completion pulse
- tx_status  out  2  00 ok, 01 timeout, 10 aborted, 11 bad length; valid from done, held until next done
- tx_byte  out  8  byte to PHY
- start_frame  out  1  to PHY
- end_frame  out  1  to PHY
- request_byte  in  1  from PHY; combinational there, high while PHY bit counter = 7
- transmitting  in  1  from PHY; registered, lags PHY state by one cycle

Behaviour:
- Reset values: busy=0, done=0, tx_status=00, start_frame=0, end_frame=0, tx_byte=0. Internal state: state=IDLE, ptr=0, counters=0. Buffer contents are not reset.
- Buffer writes: accepted only when busy=0; ignored while busy.
- tx_byte = buf[ptr], registered, updated in the cycle after ptr changes. The first byte is presented at least one cycle before the first request.
- IDLE, with tx_go=1:
  - If tx_len=0 or tx_len>DEPTH: done pulse, status 11, stay IDLE.
  - Otherwise latch len, ptr=0, gap=0, tmo=0, go to DEFER.
- DEFER:
  - gap increments while line_idle=1 and clears when line_idle=0. tmo increments every cycle.
  - gap reaches IDLE_GAP: go to START.
  - tmo reaches TIMEOUT: done, status 01, go to IDLE.
  - tx_abort: done, status 10, go to IDLE.
  - If both exit conditions hit in the same cycle, abort beats timeout, which beats start.
- START: start_frame=1 for exactly one cycle, then go to SEND.
- SEND, request handling:
  - The PHY may hold request_byte high for several cycles (bit-stuff cycles). The controller keeps tx_byte and end_frame stable while request_byte=1.
  - A request is consumed on its falling edge: req_d=1 and request_byte=0, where req_d is request_byte registered.
  - On each consumed request with ptr<len: ptr increments.
  - end_frame = (ptr==len), or abort_pending. It is registered and stable before the request it applies to.
- SEND, frame end and abort:
  - A consumed request while end_frame=1 goes to DRAIN.
  - tx_abort in SEND sets abort_pending; the frame ends at the next request and the status becomes 10.
- DRAIN: wait for transmitting=0, then done pulse with status 00 (or 10 if abort_pending), then IDLE.
- Byte count: len data bytes produce len+1 consumed requests. The first request occurs during the start flag; the last, with end_frame=1, triggers the PHY end flag.
- busy = (state!=IDLE). done and busy-fall occur in the same cycle.
- tx_go while busy: ignored. tx_abort in IDLE or DRAIN: ignored.
- Reset mid-frame: immediate return to the reset values. The PHY is reset by the same signal.

Test Plan:
- Load 0x00,0x55,0xAA, tx_len=3, line_idle=1, tx_go -> start_frame after 16 idle cycles. PHY emits flag, 3 bytes, flag. end_frame high only for the 4th request. done with status 00. No stuffing, so done within 50 cycles of start_frame.
- Byte 0xFF x2 -> the PHY stuff cycle holds request_byte high 2 cycles. ptr advances once per request. The line carries 0xFF,0xFF with inserted zeros. Status 00.
- line_idle toggles low every 10 cycles, TIMEOUT=200 -> no start_frame. done at cycle 200 with status 01. busy falls.
- tx_abort asserted mid-byte-2 of an 8-byte frame -> end_frame at the next request, flag sent, done with status 10. Remaining bytes are not sent.
- tx_len=0, then tx_len=DEPTH+1 -> immediate done, status 11, no start_frame.
- Buffer write during SEND ignored (readback after done unchanged). Reset asserted during DEFER returns all outputs to their reset values and a subsequent tx_go works.
